vga_hue_pattern_gen: RTL and testbench

//  Parametrised rainbow pattern source for the VGA pipeline; sits between timing gen and RGB out mux.

---
 rtl/vga_hue_pattern_gen.sv | 132 +++++++++++++
 tb/tb_vga_hue_pattern_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_hue_pattern_gen.sv
`timescale 1ns/1ps
// Rainbow pattern source: walks a six-segment saturated hue wheel per frame, line and pixel.
// It offers solid, horizontal, vertical and diagonal gradients, with a reversible and pausable base hue.
module vga_hue_pattern_gen #(
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned BASE_STEP = 1,
    parameter int unsigned LINE_STEP = 1,
    parameter int unsigned PIX_STEP  = 1
) (
    input  logic                   VGA_CLK,
    input  logic                   RST_N,
    input  logic                   RGB_EN,
    input  logic [10:0]            DISPLAY_X,
    input  logic [10:0]            DISPLAY_Y,
    input  logic [10:0]            CURRENT_X,
    input  logic [10:0]            CURRENT_Y,
    input  logic [1:0]             MODE,
    input  logic                   DIR,
    input  logic                   PAUSE,
    output logic [3*COLOR_W-1:0]   VGA_RGB,
    output logic                   FRAME_TICK
);

    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef logic [COLOR_W-1:0] chan_t;
    typedef logic [RGB_W-1:0]   rgb_t;
    typedef enum logic [1:0] {SOLID = 2'd0, H_GRAD = 2'd1, V_GRAD = 2'd2, DIAG = 2'd3} mode_e;

    localparam chan_t             CH_MAX   = '1;
    localparam chan_t             CH_ZERO  = '0;
    localparam rgb_t              RED      = {CH_MAX, CH_ZERO, CH_ZERO};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_DIV - 1);

    function automatic chan_t ch_up(input chan_t v, input int unsigned s);
        if (s >= 32'(CH_MAX) - 32'(v)) return CH_MAX;
        return v + chan_t'(s);
    endfunction

    function automatic chan_t ch_down(input chan_t v, input int unsigned s);
        if (s >= 32'(v)) return CH_ZERO;
        return v - chan_t'(s);
    endfunction

    // One step along the wheel: only the segment's moving channel changes, and it saturates
    // at the segment end. The following call then moves on into the next segment.
    function automatic rgb_t adv(input rgb_t c, input int unsigned s, input logic rev);
        chan_t r;
        chan_t g;
        chan_t b;
        rgb_t  res;
        r   = c[RGB_W-1 -: COLOR_W];
        g   = c[2*COLOR_W-1 -: COLOR_W];
        b   = c[COLOR_W-1:0];
        res = RED;
        if (!rev) begin
            if      (r == CH_MAX && b == CH_ZERO && g != CH_MAX)  res = {r, ch_up(g, s), b};
            else if (g == CH_MAX && b == CH_ZERO && r != CH_ZERO) res = {ch_down(r, s), g, b};
            else if (g == CH_MAX && r == CH_ZERO && b != CH_MAX)  res = {r, g, ch_up(b, s)};
            else if (b == CH_MAX && r == CH_ZERO && g != CH_ZERO) res = {r, ch_down(g, s), b};
            else if (b == CH_MAX && g == CH_ZERO && r != CH_MAX)  res = {ch_up(r, s), g, b};
            else if (r == CH_MAX && g == CH_ZERO && b != CH_ZERO) res = {r, g, ch_down(b, s)};
        end else begin
            if      (r == CH_MAX && g == CH_ZERO && b != CH_MAX)  res = {r, g, ch_up(b, s)};
            else if (b == CH_MAX && g == CH_ZERO && r != CH_ZERO) res = {ch_down(r, s), g, b};
            else if (b == CH_MAX && r == CH_ZERO && g != CH_MAX)  res = {r, ch_up(g, s), b};
            else if (g == CH_MAX && r == CH_ZERO && b != CH_ZERO) res = {r, g, ch_down(b, s)};
            else if (g == CH_MAX && b == CH_ZERO && r != CH_MAX)  res = {ch_up(r, s), g, b};
            else if (r == CH_MAX && b == CH_ZERO && g != CH_ZERO) res = {r, ch_down(g, s), b};
        end
        return res;
    endfunction

    rgb_t             base_hue;
    rgb_t             line_hue;
    rgb_t             pix_hue;
    logic [CNT_W-1:0] frame_cnt;
    mode_e            mode_q;
    logic             dir_q;

    logic line_end;
    logic frame_end;
    logic base_adv;
    rgb_t base_next;
    rgb_t line_next;
    rgb_t pix_next;

    // A zero display size must not alias to 11'h7FF through the minus-one.
    assign line_end  = RGB_EN && (DISPLAY_X != 11'd0) && (CURRENT_X == DISPLAY_X - 11'd1);
    assign frame_end = line_end && (DISPLAY_Y != 11'd0) && (CURRENT_Y == DISPLAY_Y - 11'd1);
    assign base_adv  = (frame_cnt == CNT_LAST) && !PAUSE;
    assign base_next = base_adv ? adv(base_hue, BASE_STEP, dir_q) : base_hue;
    assign line_next = adv(line_hue, LINE_STEP, dir_q);
    assign pix_next  = adv(pix_hue, PIX_STEP, dir_q);

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            VGA_RGB    <= '0;
            FRAME_TICK <= 1'b0;
            base_hue   <= RED;
            line_hue   <= RED;
            pix_hue    <= RED;
            frame_cnt  <= '0;
            mode_q     <= SOLID;
            dir_q      <= 1'b0;
        end else begin
            VGA_RGB    <= RGB_EN ? pix_hue : '0;
            FRAME_TICK <= frame_end;
            if (frame_end) begin
                // Mode and direction change only here, so a frame never tears.
                base_hue <= base_next;
                line_hue <= base_next;
                pix_hue  <= base_next;
                if (!PAUSE) frame_cnt <= base_adv ? '0 : frame_cnt + CNT_W'(1);
                mode_q   <= mode_e'(MODE);
                dir_q    <= DIR;
            end else if (line_end) begin
                if (mode_q == V_GRAD || mode_q == DIAG) begin
                    line_hue <= line_next;
                    pix_hue  <= line_next;
                end else begin
                    pix_hue <= line_hue;
                end
            end else if (RGB_EN && (mode_q == H_GRAD || mode_q == DIAG)) begin
                pix_hue <= pix_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_hue_pattern_gen.sv
`timescale 1ns/1ps
// Directed bench for vga_hue_pattern_gen on a 4x3 display; instance a uses unit steps,
// instance b uses PIX_STEP=100 and FRAME_DIV=3, and both see the same stimulus.
module tb_vga_hue_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] disp_x;
    logic [10:0] disp_y;
    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [1:0]  mode;
    logic        dir;
    logic        pause;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
    logic        tick_a;
    logic        tick_b;

    always #5 clk = ~clk;

    vga_hue_pattern_gen #(
        .COLOR_W(8), .FRAME_DIV(1), .BASE_STEP(1), .LINE_STEP(1), .PIX_STEP(1)
    ) dut_a (
        .VGA_CLK(clk), .RST_N(rst_n), .RGB_EN(en),
        .DISPLAY_X(disp_x), .DISPLAY_Y(disp_y), .CURRENT_X(cur_x), .CURRENT_Y(cur_y),
        .MODE(mode), .DIR(dir), .PAUSE(pause), .VGA_RGB(rgb_a), .FRAME_TICK(tick_a)
    );

    vga_hue_pattern_gen #(
        .COLOR_W(8), .FRAME_DIV(3), .BASE_STEP(1), .LINE_STEP(1), .PIX_STEP(100)
    ) dut_b (
        .VGA_CLK(clk), .RST_N(rst_n), .RGB_EN(en),
        .DISPLAY_X(disp_x), .DISPLAY_Y(disp_y), .CURRENT_X(cur_x), .CURRENT_Y(cur_y),
        .MODE(mode), .DIR(dir), .PAUSE(pause), .VGA_RGB(rgb_b), .FRAME_TICK(tick_b)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
        logic        exp_tick;
    } vec_t;

    vec_t        vec[12];
    logic [23:0] hg_a[4];
    logic [23:0] hg_b[4];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic drive(input logic e, input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        en    = e;
        cur_x = x;
        cur_y = y;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_grid();
        for (int i = 0; i < 12; i++) begin
            vec[i].x        = 11'(i % 4);
            vec[i].y        = 11'(i / 4);
            vec[i].exp_tick = (i == 11);
        end
    endtask

    task automatic fill_solid(input logic [23:0] a, input logic [23:0] b);
        fill_grid();
        for (int i = 0; i < 12; i++) begin
            vec[i].exp_a = a;
            vec[i].exp_b = b;
        end
    endtask

    // Plays one frame from vec[]; before pixel chg_at the mode/dir/pause inputs switch.
    task automatic run_frame(input string tag, input int chg_at,
                             input logic [1:0] m2, input logic d2, input logic p2);
        for (int i = 0; i < 12; i++) begin
            if (i == chg_at) begin
                mode  = m2;
                dir   = d2;
                pause = p2;
            end
            drive(1'b1, vec[i].x, vec[i].y);
            check($sformatf("%s rgb_a(%0d,%0d)", tag, vec[i].x, vec[i].y), rgb_a, vec[i].exp_a);
            check($sformatf("%s rgb_b(%0d,%0d)", tag, vec[i].x, vec[i].y), rgb_b, vec[i].exp_b);
            check($sformatf("%s tick_a(%0d,%0d)", tag, vec[i].x, vec[i].y), {23'd0, tick_a}, {23'd0, vec[i].exp_tick});
            check($sformatf("%s tick_b(%0d,%0d)", tag, vec[i].x, vec[i].y), {23'd0, tick_b}, {23'd0, vec[i].exp_tick});
            if (vec[i].x == 11'd3) begin
                drive(1'b0, 11'd0, 11'd0);
                check($sformatf("%s blank_a y%0d", tag, vec[i].y), rgb_a, 24'h000000);
                check($sformatf("%s blank_b y%0d", tag, vec[i].y), rgb_b, 24'h000000);
            end
        end
    endtask

    initial begin
        logic [23:0] ea;
        logic [23:0] eb;
        hg_a = '{24'hFF0000, 24'hFF0100, 24'hFF0200, 24'hFF0300};
        hg_b = '{24'hFF0000, 24'hFF6400, 24'hFFC800, 24'hFFFF00};

        // Reset with video disabled.
        rst_n = 1'b0; en = 1'b0; disp_x = 11'd4; disp_y = 11'd3;
        cur_x = 11'd0; cur_y = 11'd0; mode = 2'd0; dir = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rgb_a", rgb_a, 24'h0);
        check("reset tick_a", {23'd0, tick_a}, 24'h0);
        check("reset rgb_b", rgb_b, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 11'd0, 11'd0);
        check("idle rgb_a", rgb_a, 24'h0);

        // SOLID forward: frame n shows FF,n,00 up to yellow, then red falls.
        for (int n = 0; n <= 300; n++) begin
            ea = (n <= 255) ? {8'hFF, 8'(n), 8'h00} : {8'(510 - n), 8'hFF, 8'h00};
            eb = {8'hFF, 8'(n / 3), 8'h00};
            fill_solid(ea, eb);
            run_frame($sformatf("solid f%0d", n), -1, 2'd0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a line.
        drive(1'b1, 11'd0, 11'd0);
        check("pre-reset rgb_a", rgb_a, 24'hD1FF00);
        check("pre-reset rgb_b", rgb_b, 24'hFF6400);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rgb_a", rgb_a, 24'h0);
        check("async reset rgb_b", rgb_b, 24'h0);
        check("async reset tick_a", {23'd0, tick_a}, 24'h0);
        drive(1'b1, 11'd1, 11'd0);
        check("in reset rgb_a", rgb_a, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pause = 1'b1;

        // Paused frame; MODE/DIR switch mid-frame must not show before the frame end.
        fill_solid(24'hFF0000, 24'hFF0000);
        run_frame("c0", 5, 2'd1, 1'b0, 1'b1);

        // H_GRAD, forward, still paused; the b instance clamps at yellow.
        fill_grid();
        for (int i = 0; i < 12; i++) begin
            vec[i].exp_a = hg_a[i % 4];
            vec[i].exp_b = hg_b[i % 4];
        end
        run_frame("hgrad", 6, 2'd3, 1'b1, 1'b1);

        // DIAG, reverse from red: blue rises by line and by pixel.
        fill_grid();
        for (int i = 0; i < 12; i++) begin
            vec[i].exp_a = {16'hFF00, 8'((i % 4) + (i / 4))};
            vec[i].exp_b = {16'hFF00, ((i % 4) == 3) ? 8'hFF : 8'(100 * (i % 4) + (i / 4))};
        end
        run_frame("diag", 6, 2'd0, 1'b1, 1'b0);

        // Unpaused reverse SOLID: b steps every third frame, counter held while paused.
        fill_solid(24'hFF0001, 24'hFF0000);
        run_frame("c3", -1, 2'd0, 1'b1, 1'b0);
        fill_solid(24'hFF0002, 24'hFF0000);
        run_frame("c4", -1, 2'd0, 1'b1, 1'b0);
        fill_solid(24'hFF0003, 24'hFF0001);
        run_frame("c5", -1, 2'd0, 1'b1, 1'b0);

        // Zero display size: no line or frame events even at coordinate 7FF.
        disp_x = 11'd0;
        disp_y = 11'd0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 11'h7FF, 11'h7FF);
            check($sformatf("dis0 rgb_a %0d", k), rgb_a, 24'hFF0004);
            check($sformatf("dis0 rgb_b %0d", k), rgb_b, 24'hFF0001);
            check($sformatf("dis0 tick_a %0d", k), {23'd0, tick_a}, 24'h0);
            check($sformatf("dis0 tick_b %0d", k), {23'd0, tick_b}, 24'h0);
        end
        disp_x = 11'd4;
        disp_y = 11'd3;
        fill_solid(24'hFF0004, 24'hFF0001);
        run_frame("c6", -1, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
